audio_mix_seq: RTL and testbench

AUDIO_MIX_SEQ -- requirements
Module: audio_mix_seq

---
 rtl/audio_mix_seq.sv | 131 +++++++++++++
 tb/tb_audio_mix_seq.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/audio_mix_seq.sv
// audio_mix_seq: tick-driven stereo mixer that sums SLOTS 8-bit sources through a per-slot enable/gain table.
// Optional build macro AUDIO_MIX_SAT_EN clamps outputs to 12'hFFF instead of wrapping.
module audio_mix_seq #(
    parameter int SLOTS = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 tick,
    input  logic [8*SLOTS-1:0]   src,
    input  logic                 cfg_we,
    input  logic [2:0]           cfg_addr,
    input  logic [3:0]           cfg_data,
    output logic [11:0]          left,
    output logic [11:0]          right,
    output logic                 valid,
    output logic                 busy,
    output logic                 overrun
);

    // state | meaning
    // IDLE  | waiting for tick
    // LATCH | snapshot held, accumulators and slot counter cleared
    // ACC   | one slot accumulated per cycle
    // DONE  | result on left/right, valid high
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LATCH = 2'd1,
        ACC   = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [8*SLOTS-1:0] snap;
    logic [3:0]         tbl [SLOTS];
    logic [2:0]         slot;
    logic               last_slot;
    logic [3:0]         entry;
    logic [7:0]         sample;
    logic [10:0]        term;
    logic [13:0]        acc_l, acc_r;
    logic [13:0]        acc_l_nxt, acc_r_nxt;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (tick) state_nxt = LATCH;
            LATCH:   state_nxt = ACC;
            ACC:     if (last_slot) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        valid = (state == DONE);
        busy  = (state != IDLE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < SLOTS; i++) begin
                tbl[i] <= 4'b1100;
            end
        end else if (cfg_we && (int'(cfg_addr) < SLOTS)) begin
            tbl[cfg_addr] <= cfg_data;
        end
    end

    // Table is read combinationally, so a write landing this cycle only affects later slots.
    always_comb begin
        last_slot = (slot == 3'(SLOTS - 1));
        entry     = tbl[slot];
        sample    = snap[{slot, 3'b000} +: 8];
        term      = {3'b000, sample} << entry[1:0];
        acc_l_nxt = acc_l + (entry[3] ? {3'b000, term} : 14'd0);
        acc_r_nxt = acc_r + (entry[2] ? {3'b000, term} : 14'd0);
    end

    // Outputs load on the final ACC edge so they are already valid during DONE.
    always_ff @(posedge clock) begin
        if (reset) begin
            snap    <= '0;
            acc_l   <= '0;
            acc_r   <= '0;
            slot    <= '0;
            left    <= '0;
            right   <= '0;
            overrun <= 1'b0;
        end else begin
            overrun <= tick && busy;
            case (state)
                IDLE: begin
                    if (tick) begin
                        snap <= src;
                    end
                end
                LATCH: begin
                    acc_l <= '0;
                    acc_r <= '0;
                    slot  <= '0;
                end
                ACC: begin
                    acc_l <= acc_l_nxt;
                    acc_r <= acc_r_nxt;
                    if (!last_slot) begin
                        slot <= slot + 3'd1;
                    end else begin
`ifdef AUDIO_MIX_SAT_EN
                        left  <= (acc_l_nxt > 14'd4095) ? 12'hFFF : acc_l_nxt[11:0];
                        right <= (acc_r_nxt > 14'd4095) ? 12'hFFF : acc_r_nxt[11:0];
`else
                        left  <= acc_l_nxt[11:0];
                        right <= acc_r_nxt[11:0];
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_audio_mix_seq.sv
// Directed self-checking bench for audio_mix_seq (SLOTS = 8).
// Expected values are hand-computed; AUDIO_MIX_SAT_EN selects the clamped expectation.
module tb_audio_mix_seq;

    localparam logic [63:0] ALL10 = {8{8'h10}};
    localparam logic [63:0] ALL20 = {8{8'h20}};
    localparam logic [63:0] ALL80 = {8{8'h80}};
    localparam logic [63:0] ALLFF = {8{8'hFF}};
`ifdef AUDIO_MIX_SAT_EN
    localparam logic [11:0] FULL_EXP = 12'hFFF;
`else
    localparam logic [11:0] FULL_EXP = 12'hFC0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        tick;
    logic [63:0] src;
    logic        cfg_we;
    logic [2:0]  cfg_addr;
    logic [3:0]  cfg_data;
    logic [11:0] left;
    logic [11:0] right;
    logic        valid;
    logic        busy;
    logic        overrun;

    int n_asrt = 0;
    int n_fail = 0;
    int first_valid;
    int nvalid;
    int nov;

    audio_mix_seq #(.SLOTS(8)) dut (
        .clock    (clock),
        .reset    (reset),
        .tick     (tick),
        .src      (src),
        .cfg_we   (cfg_we),
        .cfg_addr (cfg_addr),
        .cfg_data (cfg_data),
        .left     (left),
        .right    (right),
        .valid    (valid),
        .busy     (busy),
        .overrun  (overrun)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
    endtask

    task automatic cfg_write(input logic [2:0] a, input logic [3:0] d);
        cfg_we   = 1'b1;
        cfg_addr = a;
        cfg_data = d;
        @(posedge clock); #1;
        cfg_we = 1'b0;
    endtask

    // Tick now, then run ncyc cycles; optional second tick, src change, reset and two table writes.
    task automatic window(input int ncyc, input int t2, input int s2_at, input logic [63:0] s2,
                          input int r_at,
                          input int wa_at, input logic [2:0] wa_addr, input logic [3:0] wa_data,
                          input int wb_at, input logic [2:0] wb_addr, input logic [3:0] wb_data);
        first_valid = -1;
        nvalid      = 0;
        nov         = 0;
        tick        = 1'b1;
        for (int c = 1; c <= ncyc; c++) begin
            @(posedge clock); #1;
            if (valid) begin
                nvalid++;
                if (first_valid < 0) first_valid = c;
            end
            if (overrun) nov++;
            tick   = (c == t2);
            reset  = (c == r_at);
            if (c == s2_at) src = s2;
            cfg_we = 1'b0;
            if (c == wa_at) begin
                cfg_we = 1'b1; cfg_addr = wa_addr; cfg_data = wa_data;
            end else if (c == wb_at) begin
                cfg_we = 1'b1; cfg_addr = wb_addr; cfg_data = wb_data;
            end
        end
        tick   = 1'b0;
        reset  = 1'b0;
        cfg_we = 1'b0;
    endtask

    task automatic plain_pass();
        window(14, -1, -1, '0, -1, -1, 3'd0, 4'd0, -1, 3'd0, 4'd0);
    endtask

    initial begin
        reset = 1'b1; tick = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0; src = '0;
        repeat (2) @(posedge clock);
        #1;
        check("rst_left", left, 12'h000);
        check("rst_right", right, 12'h000);
        check("rst_valid", valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_overrun", overrun, 1'b0);
        reset = 1'b0;

        // default table, all sources 0x10
        src = ALL10;
        plain_pass();
        check("dflt_latency", first_valid, 10);
        check("dflt_nvalid", nvalid, 1);
        check("dflt_overrun", nov, 0);
        check("dflt_left", left, 12'h080);
        check("dflt_right", right, 12'h080);
        check("dflt_busy_after", busy, 1'b0);

        // slot 0 left only, gain x8
        cfg_write(3'd0, 4'b1011);
        src = 64'h00000000000000FF;
        plain_pass();
        check("gain_latency", first_valid, 10);
        check("gain_left", left, 12'h7F8);
        check("gain_right", right, 12'h000);

        // mixed routing: slot2 left x2, slot5 right x4, ramp sources
        do_reset();
        cfg_write(3'd2, 4'b1001);
        cfg_write(3'd5, 4'b0110);
        src = 64'h0807060504030201;
        plain_pass();
        check("mix_left", left, 12'h021);
        check("mix_right", right, 12'h033);

        // table writes mid-pass: slot3 written in its own cycle (old entry used), slot7 ahead (new entry)
        do_reset();
        src = ALL10;
        window(14, -1, -1, '0, -1, 5, 3'd3, 4'b1000, 6, 3'd7, 4'b0111);
        check("midw_left", left, 12'h070);
        check("midw_right", right, 12'h0F0);
        plain_pass();
        check("midw_next_left", left, 12'h070);
        check("midw_next_right", right, 12'h0E0);

        // second tick during ACC with src change: one overrun, one valid, first snapshot
        do_reset();
        src = ALL10;
        window(20, 4, 4, ALL20, -1, -1, 3'd0, 4'd0, -1, 3'd0, 4'd0);
        check("ovr_count", nov, 1);
        check("ovr_nvalid", nvalid, 1);
        check("ovr_latency", first_valid, 10);
        check("ovr_left", left, 12'h080);
        check("ovr_right", right, 12'h080);

        // tick in DONE cycle is an overrun and starts nothing
        src = ALL10;
        window(24, 10, -1, '0, -1, -1, 3'd0, 4'd0, -1, 3'd0, 4'd0);
        check("done_tick_ovr", nov, 1);
        check("done_tick_nvalid", nvalid, 1);
        check("done_tick_left", left, 12'h080);

        // source change one cycle after tick must not reach this pass
        src = ALL10;
        window(14, -1, 1, ALL80, -1, -1, 3'd0, 4'd0, -1, 3'd0, 4'd0);
        check("snap_left", left, 12'h080);
        check("snap_right", right, 12'h080);

        // full scale: every slot both sides x8
        for (int i = 0; i < 8; i++) cfg_write(3'(i), 4'b1111);
        src = ALLFF;
        plain_pass();
        check("full_left", left, FULL_EXP);
        check("full_right", right, FULL_EXP);

        // reset mid-pass aborts and restores the table
        src = ALL10;
        window(20, -1, -1, '0, 5, -1, 3'd0, 4'd0, -1, 3'd0, 4'd0);
        check("abort_nvalid", nvalid, 0);
        check("abort_overrun", nov, 0);
        check("abort_left", left, 12'h000);
        check("abort_right", right, 12'h000);
        check("abort_busy", busy, 1'b0);
        plain_pass();
        check("abort_tbl_left", left, 12'h080);
        check("abort_tbl_right", right, 12'h080);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
